pixel_spike_encoder: RTL

Rate-coding spike encoder that turns one image of M 8-bit pixel intensities into M parallel spike trains over T timesteps. It sits directly upstream of the input neuron block and drives that block's per-lane `spike_in` bus, its `start` strobe and its `start_core_img` image-boundary strobe. In the default build, each lane uses a deterministic phase accumulator. An optional build uses a shared LFSR to produce pseudo-Poisson spike trains.

---
 rtl/pixel_spike_encoder_pkg.sv | 32 +++
 rtl/pixel_spike_encoder_enc_lane.sv | 83 ++++++++
 rtl/pixel_spike_encoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pixel_spike_encoder_pkg.sv
// Shared types and helpers for the rate-coding pixel spike encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pixel_spike_encoder_pkg;

  localparam int PIX_W  = 8;
  localparam int LFSR_W = 16;

  // Encoder FSM: IDLE waits for a start, RUN emits T timesteps.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } enc_state_e;

  // One left shift of the Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Low byte of the LFSR rotated left by (lane mod 16); gives each lane its own threshold.
  function automatic logic [PIX_W-1:0] lfsr_lane_byte(input logic [LFSR_W-1:0] s,
                                                      input int unsigned       lane);
    logic [PIX_W-1:0] b;
    int unsigned      rot;
    rot = lane % 16;
    for (int unsigned j = 0; j < 8; j++) begin
      b[j] = s[(j + 16 - rot) % 16];
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_spike_encoder_enc_lane.sv
// One spike lane: latches its pixel on load, emits one registered spike per step (ENC_POISSON_EN selects LFSR compare).
// Latency: spike for a step is registered on the edge that ends that step.
// Backpressure: none; the lane advances whenever step_en is high.
module enc_lane
  import pixel_spike_encoder_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step_en,
  input  logic [PIX_W-1:0] pix_in,
`ifdef ENC_POISSON_EN
  input  logic [LFSR_W-1:0] lfsr,
`endif
  output logic             spike_out
);

  logic [PIX_W-1:0] pix_q, pix_d;
  logic             spike_q, spike_d;

`ifdef ENC_POISSON_EN
  logic [PIX_W-1:0] thresh;

  // Spike when the latched intensity beats this lane's view of the shared LFSR.
  always_comb begin
    pix_d   = pix_q;
    spike_d = 1'b0;
    thresh  = lfsr_lane_byte(lfsr, LANE);
    if (load) begin
      pix_d = pix_in;
    end else if (step_en) begin
      spike_d = (pix_q > thresh);
    end
  end

  // Lane state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      spike_q <= spike_d;
    end
  end
`else
  logic [PIX_W-1:0] acc_q, acc_d;
  logic [PIX_W:0]   sum;

  // Phase accumulator: the carry out of acc + pixel is the spike.
  always_comb begin
    pix_d   = pix_q;
    acc_d   = acc_q;
    spike_d = 1'b0;
    sum     = {1'b0, acc_q} + {1'b0, pix_q};
    if (load) begin
      pix_d = pix_in;
      acc_d = '0;
    end else if (step_en) begin
      spike_d = sum[PIX_W];
      acc_d   = sum[PIX_W-1:0];
    end
  end

  // Lane state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q   <= '0;
      acc_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      acc_q   <= acc_d;
      spike_q <= spike_d;
    end
  end
`endif

  assign spike_out = spike_q;

endmodule

// File: rtl/pixel_spike_encoder.sv
// Rate-coding encoder: one image of M pixels -> M spike trains over T steps (ENC_POISSON_EN selects shared LFSR).
// Latency: first spike_valid cycle one clock after the accepted start_enc edge; T valid cycles per image.
// Backpressure: none; start_enc is honoured only in IDLE and dropped (not queued) while busy.
module pixel_spike_encoder
  import pixel_spike_encoder_pkg::*;
#(
  parameter int          M    = 784,
  parameter int          T    = 24,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8*M-1:0]   pixel_in,
  input  logic             start_enc,
  output logic [M-1:0]     spike_out,
  output logic             spike_valid,
  output logic             img_start,
  output logic             done_enc,
  output logic             busy
);

  localparam int            SW    = $clog2(T + 1);
  localparam logic [SW-1:0] T_CNT = SW'(T);
  localparam logic [SW-1:0] ONE   = SW'(1);

  // Reject illegal configurations at elaboration time.
  if (T < 1 || T > 255) begin : g_bad_t
    $error("pixel_spike_encoder: T must be in 1..255");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("pixel_spike_encoder: SEED must be nonzero");
  end

  enc_state_e    state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic          spike_valid_q, spike_valid_d;
  logic          img_start_q, img_start_d;
  logic          done_enc_q, done_enc_d;
  logic          busy_q, busy_d;
  logic          accept;
  logic          run;

  assign accept = (state_q == ST_IDLE) && start_enc;
  assign run    = (state_q == ST_RUN);

  // Next-state, saturating step counter and registered handshake strobes.
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    spike_valid_d = run;
    busy_d        = run;
    img_start_d   = run && (step_q == ONE);
    done_enc_d    = run && (step_q == T_CNT);
    case (state_q)
      ST_IDLE: begin
        if (start_enc) begin
          state_d = ST_RUN;
          step_d  = ONE;
        end
      end
      ST_RUN: begin
        if (step_q == T_CNT) begin
          state_d = ST_IDLE;
        end else begin
          step_d = step_q + ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      spike_valid_q <= 1'b0;
      img_start_q   <= 1'b0;
      done_enc_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      spike_valid_q <= spike_valid_d;
      img_start_q   <= img_start_d;
      done_enc_q    <= done_enc_d;
      busy_q        <= busy_d;
    end
  end

`ifdef ENC_POISSON_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // Reload on every accepted image so identical pixels give identical trains; advance after each use.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      lfsr_d = SEED;
    end else if (run) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  for (genvar i = 0; i < M; i++) begin : g_lane
    enc_lane #(
      .LANE(i)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .step_en  (run),
      .pix_in   (pixel_in[8*i +: 8]),
`ifdef ENC_POISSON_EN
      .lfsr     (lfsr_q),
`endif
      .spike_out(spike_out[i])
    );
  end

  assign spike_valid = spike_valid_q;
  assign img_start   = img_start_q;
  assign done_enc    = done_enc_q;
  assign busy        = busy_q;

endmodule
